// File: rtl/shift_register_mc.sv
// Multi-channel full-duplex shift register: serialises N_CH words in lock-step
// while capturing N_CH serial inputs, with programmable length and bit order.
module shift_register_mc #(
  parameter int NB_REG = 32,
  parameter int N_CH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [$clog2(NB_REG):0]    i_nbits,
  input  logic                       i_lsb_first,
  input  logic                       i_abort,
  input  logic [N_CH*NB_REG-1:0]     value,
  input  logic [N_CH-1:0]            i_sdi,
  output logic [N_CH-1:0]            o_data,
  output logic [N_CH*NB_REG-1:0]     o_rdata,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int CW = $clog2(NB_REG) + 1;
  localparam int IW = $clog2(NB_REG);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     len_q;
  logic [CW-1:0]     len_in;
  logic              lsb_q;
  logic [NB_REG-1:0] tx_q  [N_CH];
  logic [NB_REG-1:0] cap_q [N_CH];
  logic [NB_REG-1:0] cap_d [N_CH];
  logic [CW-1:0]     pos_full;
  logic [IW-1:0]     pos;
  logic              step;
  logic              last;

  // Zero or oversize lengths both fall back to the full register width
  always_comb begin
    len_in = i_nbits;
    if (i_nbits == '0 || i_nbits > CW'(NB_REG)) begin
      len_in = CW'(NB_REG);
    end
  end

  // Transmit and capture share one bit position, so loopback returns the word
  // masked to L bits regardless of bit order.
  assign pos_full = lsb_q ? cnt_q : (len_q - CW'(1) - cnt_q);
  assign pos      = pos_full[IW-1:0];
  assign step     = (state_q == SHIFT) && en && !i_abort;
  assign last     = step && (cnt_q == len_q - CW'(1));

  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q == SHIFT);
  assign o_done  = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = SHIFT;
      SHIFT: begin
        if (i_abort)   state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      cap_d[k] = cap_q[k];
      if (step) cap_d[k][pos] = i_sdi[k];
      if (state_q == SHIFT) o_data[k] = tx_q[k][pos];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      lsb_q   <= 1'b0;
      o_rdata <= '0;
      for (int k = 0; k < N_CH; k++) begin
        tx_q[k]  <= '0;
        cap_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && i_valid) begin
        cnt_q <= '0;
        len_q <= len_in;
        lsb_q <= i_lsb_first;
        for (int k = 0; k < N_CH; k++) begin
          tx_q[k]  <= value[k*NB_REG +: NB_REG];
          cap_q[k] <= '0;
        end
      end else if (step) begin
        cnt_q <= cnt_q + CW'(1);
        for (int k = 0; k < N_CH; k++) begin
          cap_q[k] <= cap_d[k];
          if (last) o_rdata[k*NB_REG +: NB_REG] <= cap_d[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_register_mc.sv
// Directed bench for shift_register_mc (NB_REG=8, N_CH=2): table of loopback
// frames plus hand-written hold-valid, abort and mid-frame reset sequences.
module tb_shift_register_mc;

  localparam int NB  = 8;
  localparam int NCH = 2;

  logic            clk;
  logic            rst;
  logic            en;
  logic            i_valid;
  logic            o_ready;
  logic [3:0]      i_nbits;
  logic            i_lsb_first;
  logic            i_abort;
  logic [15:0]     value;
  logic [1:0]      i_sdi;
  logic [1:0]      sdi_man;
  logic            loopback;
  logic [1:0]      o_data;
  logic [15:0]     o_rdata;
  logic            o_busy;
  logic            o_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] val;
    logic [3:0]  nbits;
    logic        lsb;
    logic [15:0] expRdata;
    int          expEns;
    logic [7:0]  expSeq0;
    logic [7:0]  expSeq1;
  } vec_t;

  vec_t vecs [5];

  shift_register_mc #(.NB_REG(NB), .N_CH(NCH)) dut (
    .clk(clk), .rst(rst), .en(en), .i_valid(i_valid), .o_ready(o_ready),
    .i_nbits(i_nbits), .i_lsb_first(i_lsb_first), .i_abort(i_abort),
    .value(value), .i_sdi(i_sdi), .o_data(o_data), .o_rdata(o_rdata),
    .o_busy(o_busy), .o_done(o_done)
  );

  assign i_sdi = loopback ? o_data : sdi_man;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshake then strobe en every 'period' cycles until o_done or budget
  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] nb, input logic lsb,
                               input int period, input logic holdValid,
                               output int ens, output logic [7:0] seq0, output logic [7:0] seq1,
                               output logic done, output int stableErr, output int busyErr);
    int cyc;
    logic lastEn;
    logic [1:0] prev;
    ens = 0; seq0 = '0; seq1 = '0; done = 1'b0; stableErr = 0; busyErr = 0; cyc = 0;
    value = v; i_nbits = nb; i_lsb_first = lsb; i_valid = 1'b1;
    tick();
    if (!holdValid) i_valid = 1'b0;
    while (!done && cyc < 200) begin
      en = ((cyc % period) == period - 1);
      lastEn = en;
      prev = o_data;
      if (!o_busy || o_ready) busyErr++;
      if (en) begin
        ens++;
        seq0 = {seq0[6:0], o_data[0]};
        seq1 = {seq1[6:0], o_data[1]};
      end
      tick();
      en = 1'b0;
      cyc++;
      if (o_done) done = 1'b1;
      else if (!lastEn && o_data !== prev) stableErr++;
    end
  endtask

  initial begin
    int ens, stableErr, busyErr;
    logic [7:0] seq0, seq1;
    logic done;

    vecs[0] = '{16'h3CA5, 4'd8,  1'b0, 16'h3CA5, 8, 8'hA5, 8'h3C};
    vecs[1] = '{16'h81F3, 4'd5,  1'b1, 16'h0113, 5, 8'h19, 8'h10};
    vecs[2] = '{16'h5AC3, 4'd0,  1'b0, 16'h5AC3, 8, 8'hC3, 8'h5A};
    vecs[3] = '{16'h1E2D, 4'd12, 1'b1, 16'h1E2D, 8, 8'hB4, 8'h78};
    vecs[4] = '{16'h0302, 4'd1,  1'b0, 16'h0100, 1, 8'h00, 8'h01};

    rst = 1'b0; en = 1'b0; i_valid = 1'b0; i_nbits = '0; i_lsb_first = 1'b0;
    i_abort = 1'b0; value = '0; sdi_man = '0; loopback = 1'b1;
    tick(); tick();
    checkOutput("reset o_data", 32'(o_data), 0);
    checkOutput("reset o_rdata", 32'(o_rdata), 0);
    checkOutput("reset o_busy", 32'(o_busy), 0);
    checkOutput("reset o_done", 32'(o_done), 0);
    rst = 1'b1;
    tick();
    checkOutput("ready after reset", 32'(o_ready), 1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].val, vecs[i].nbits, vecs[i].lsb, 1, 1'b0,
                    ens, seq0, seq1, done, stableErr, busyErr);
      checkOutput($sformatf("v%0d done", i), 32'(done), 1);
      checkOutput($sformatf("v%0d ens", i), 32'(ens), 32'(vecs[i].expEns));
      checkOutput($sformatf("v%0d seq0", i), 32'(seq0), 32'(vecs[i].expSeq0));
      checkOutput($sformatf("v%0d seq1", i), 32'(seq1), 32'(vecs[i].expSeq1));
      checkOutput($sformatf("v%0d rdata", i), 32'(o_rdata), 32'(vecs[i].expRdata));
      checkOutput($sformatf("v%0d busy", i), 32'(busyErr), 0);
      checkOutput($sformatf("v%0d done ready", i), 32'(o_ready), 0);
      checkOutput($sformatf("v%0d done data", i), 32'(o_data), 0);
      tick();
      checkOutput($sformatf("v%0d done pulse", i), 32'(o_done), 0);
      checkOutput($sformatf("v%0d ready back", i), 32'(o_ready), 1);
    end

    // Sparse strobes with i_valid held: the reload may only happen after DONE
    applyStimulus(16'h1234, 4'd8, 1'b0, 3, 1'b1, ens, seq0, seq1, done, stableErr, busyErr);
    checkOutput("hold done", 32'(done), 1);
    checkOutput("hold ens", 32'(ens), 8);
    checkOutput("hold stable", 32'(stableErr), 0);
    checkOutput("hold busy", 32'(busyErr), 0);
    checkOutput("hold rdata", 32'(o_rdata), 32'h1234);
    checkOutput("hold done ready", 32'(o_ready), 0);
    tick();
    checkOutput("hold idle ready", 32'(o_ready), 1);
    tick();
    checkOutput("hold reload busy", 32'(o_busy), 1);
    i_valid = 1'b0;
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    checkOutput("hold abort idle", 32'(o_ready), 1);

    // Abort after three strobes, with en also high to confirm abort priority
    value = 16'hFFFF; i_nbits = 4'd8; i_lsb_first = 1'b0; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    en = 1'b1;
    tick(); tick(); tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0; en = 1'b0;
    checkOutput("abort ready", 32'(o_ready), 1);
    checkOutput("abort busy", 32'(o_busy), 0);
    checkOutput("abort done", 32'(o_done), 0);
    checkOutput("abort data", 32'(o_data), 0);
    checkOutput("abort rdata", 32'(o_rdata), 32'h1234);
    applyStimulus(16'h6699, 4'd8, 1'b0, 1, 1'b0, ens, seq0, seq1, done, stableErr, busyErr);
    checkOutput("reload done", 32'(done), 1);
    checkOutput("reload rdata", 32'(o_rdata), 32'h6699);
    tick();

    // Reset pulse mid-frame clears everything and never produces o_done
    value = 16'h0F0F; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    en = 1'b1;
    tick(); tick(); tick(); tick();
    rst = 1'b0;
    tick();
    checkOutput("midrst data", 32'(o_data), 0);
    checkOutput("midrst rdata", 32'(o_rdata), 0);
    checkOutput("midrst busy", 32'(o_busy), 0);
    checkOutput("midrst done", 32'(o_done), 0);
    rst = 1'b1;
    tick();
    en = 1'b0;
    checkOutput("midrst ready", 32'(o_ready), 1);
    checkOutput("midrst no done", 32'(o_done), 0);
    checkOutput("midrst idle busy", 32'(o_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
